// File: rtl/frac_pkg.sv
// Shared Q8.24 constants, coefficient reset defaults and FSM state encoding
// for the fractional-order channel scheduler.
package frac_pkg;

   localparam int          Q_FRAC         = 24;
   localparam logic [31:0] ONE            = 32'd16777216;
   localparam logic [31:0] FRAC_ALPHA_RST = 32'd8388608;
   localparam logic [31:0] FRAC_K_RST     = 32'd16861102;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_MUL_A = 3'd1;
   localparam state_t ST_MUL_K = 3'd2;
   localparam state_t ST_MUL_R = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/frac_rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last winner,
// gives a one-hot grant plus encoded index, and advances on adv_i.
module frac_rr_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = 3
) (
   input  logic            clk_100HZ,
   input  logic            Rst_n,
   input  logic [N_CH-1:0] req_i,
   input  logic            adv_i,
   output logic [N_CH-1:0] gnt_o,
   output logic [CH_W-1:0] idx_o,
   output logic            any_o
);

   logic [CH_W-1:0] ptr;

   // First requester strictly after ptr, wrapping N_CH-1 -> 0.
   always_comb begin
      int unsigned cand;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int unsigned i = 1; i <= unsigned'(N_CH); i++) begin
         cand = (32'(ptr) + i) % unsigned'(N_CH);
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = CH_W'(cand);
            gnt_o[cand] = 1'b1;
         end
      end
   end

   // Pointer remembers the last winner; reset so channel 0 wins first.
   always_ff @(posedge clk_100HZ) begin
      if (!Rst_n)
         ptr <= CH_W'(N_CH - 1);
      else if (adv_i)
         ptr <= idx_o;
   end

endmodule

// File: rtl/frac_channel_scheduler.sv
// Time-multiplexed deformable-derivative datapath: round-robin over N_CH
// channels, per-channel previous sample, three multiplies through one
// shared 32x32 signed multiplier, runtime-writable ALPHA / STEP_BETA.
module frac_channel_scheduler
   import frac_pkg::*;
#(
   parameter int          N_CH      = 4,
   parameter int          CH_W      = 3,
   parameter logic [31:0] ALPHA_RST = FRAC_ALPHA_RST,
   parameter logic [31:0] K_RST     = FRAC_K_RST,
   parameter int          RATE      = 100
) (
   input  logic               clk_100HZ,
   input  logic               Rst_n,
   input  logic [N_CH-1:0]    req_i,
   input  logic [32*N_CH-1:0] sample_i,
   output logic [N_CH-1:0]    gnt_o,
   output logic               busy_o,
   output logic [31:0]        out_o,
   output logic [CH_W-1:0]    out_ch_o,
   output logic               out_valid_o,
   input  logic               cfg_we_i,
   input  logic [31:0]        cfg_alpha_i,
   input  logic [31:0]        cfg_k_i,
   output logic               cfg_ack_o
);

   state_t          state;
   logic [31:0]     alpha, k;
   logic [31:0]     x, d, t;
   logic [CH_W-1:0] c;
   logic [31:0]     prev [N_CH];

   logic [N_CH-1:0] arb_gnt;
   logic [CH_W-1:0] arb_idx;
   logic            arb_any;
   logic            take;
   logic [31:0]     sel_sample, sel_prev;
   logic [31:0]     mul_a, mul_b;
   logic [55:0]     prod;

   // A grant is only taken in IDLE when no coefficient write competes.
   assign take   = Rst_n && (state == ST_IDLE) && !cfg_we_i && arb_any;
   assign gnt_o  = take ? arb_gnt : '0;
   assign busy_o = (state != ST_IDLE);

   frac_rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_arb (
      .clk_100HZ (clk_100HZ),
      .Rst_n     (Rst_n),
      .req_i     (req_i),
      .adv_i     (take),
      .gnt_o     (arb_gnt),
      .idx_o     (arb_idx),
      .any_o     (arb_any)
   );

   // Select the winning channel's sample and stored previous sample.
   always_comb begin
      sel_sample = '0;
      sel_prev   = '0;
      for (int unsigned i = 0; i < unsigned'(N_CH); i++) begin
         if (CH_W'(i) == arb_idx) begin
            sel_sample = sample_i[i*32 +: 32];
            sel_prev   = prev[i];
         end
      end
   end

   // Shared multiplier operand steering; only bits [55:0] are ever consumed.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         ST_MUL_A: begin mul_a = d; mul_b = alpha;       end
         ST_MUL_K: begin mul_a = t; mul_b = k;           end
         ST_MUL_R: begin mul_a = t; mul_b = 32'(RATE);   end
         default:  begin mul_a = '0; mul_b = '0;         end
      endcase
      prod = {{24{mul_a[31]}}, mul_a} * {{24{mul_b[31]}}, mul_b};
   end

   // Sequencer: config/grant in IDLE, then three multiply steps and a result pulse.
   always_ff @(posedge clk_100HZ) begin
      if (!Rst_n) begin
         state       <= ST_IDLE;
         alpha       <= ALPHA_RST;
         k           <= K_RST;
         x           <= '0;
         d           <= '0;
         t           <= '0;
         c           <= '0;
         out_o       <= '0;
         out_ch_o    <= '0;
         out_valid_o <= 1'b0;
         cfg_ack_o   <= 1'b0;
         for (int unsigned i = 0; i < unsigned'(N_CH); i++)
            prev[i] <= '0;
      end else begin
         out_valid_o <= 1'b0;
         cfg_ack_o   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_we_i) begin
                  alpha     <= cfg_alpha_i;
                  k         <= cfg_k_i;
                  cfg_ack_o <= 1'b1;
               end else if (arb_any) begin
                  x     <= sel_sample;
                  c     <= arb_idx;
                  d     <= sel_sample - sel_prev;
                  state <= ST_MUL_A;
               end
            end
            ST_MUL_A: begin
               t     <= prod[Q_FRAC+31:Q_FRAC] + x;
               state <= ST_MUL_K;
            end
            ST_MUL_K: begin
               t     <= prod[Q_FRAC+31:Q_FRAC] - x;
               state <= ST_MUL_R;
            end
            ST_MUL_R: begin
               out_o       <= prod[31:0];
               out_ch_o    <= c;
               out_valid_o <= 1'b1;
               for (int unsigned i = 0; i < unsigned'(N_CH); i++)
                  if (CH_W'(i) == c)
                     prev[i] <= x;
               state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frac_channel_scheduler.sv
// Directed self-checking bench for frac_channel_scheduler.
module tb_frac_channel_scheduler;
   import frac_pkg::*;

   localparam int N_CH = 4;
   localparam int CH_W = 3;

   logic               clk_100HZ = 1'b0;
   logic               Rst_n;
   logic [N_CH-1:0]    req_i;
   logic [32*N_CH-1:0] sample_i;
   logic [N_CH-1:0]    gnt_o;
   logic               busy_o;
   logic [31:0]        out_o;
   logic [CH_W-1:0]    out_ch_o;
   logic               out_valid_o;
   logic               cfg_we_i;
   logic [31:0]        cfg_alpha_i;
   logic [31:0]        cfg_k_i;
   logic               cfg_ack_o;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] X_POS = 32'd16777216;
   localparam logic [31:0] X_NEG = 32'hFF000000;

   frac_channel_scheduler #(
      .N_CH      (N_CH),
      .CH_W      (CH_W),
      .ALPHA_RST (32'd8388608),
      .K_RST     (32'd16861102),
      .RATE      (100)
   ) dut (
      .clk_100HZ   (clk_100HZ),
      .Rst_n       (Rst_n),
      .req_i       (req_i),
      .sample_i    (sample_i),
      .gnt_o       (gnt_o),
      .busy_o      (busy_o),
      .out_o       (out_o),
      .out_ch_o    (out_ch_o),
      .out_valid_o (out_valid_o),
      .cfg_we_i    (cfg_we_i),
      .cfg_alpha_i (cfg_alpha_i),
      .cfg_k_i     (cfg_k_i),
      .cfg_ack_o   (cfg_ack_o)
   );

   always #5 clk_100HZ = ~clk_100HZ;

   task automatic tick();
      @(posedge clk_100HZ);
      #1;
   endtask

   task automatic do_reset();
      Rst_n       = 1'b0;
      req_i       = '0;
      sample_i    = '0;
      cfg_we_i    = 1'b0;
      cfg_alpha_i = '0;
      cfg_k_i     = '0;
      tick();
      tick();
      Rst_n = 1'b1;
   endtask

   // Issue one request on channel ch and collect grant, latency and result.
   task automatic txn(input int ch, input logic [31:0] x,
                      output logic [N_CH-1:0] g, output int lat,
                      output logic [31:0] y, output logic [CH_W-1:0] och);
      req_i            = '0;
      req_i[ch]        = 1'b1;
      sample_i[ch*32 +: 32] = x;
      #1;
      g = gnt_o;
      tick();
      req_i = '0;
      lat = -1;
      y   = '0;
      och = '0;
      for (int i = 1; i <= 20; i++) begin
         if (out_valid_o) begin
            lat = i;
            y   = out_o;
            och = out_ch_o;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      req_i = '1;
      sample_i = '1;
      cfg_we_i = 1'b0;
      tick();
      #1;
      checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b want=0000", gnt_o); end
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      checks++; if (out_o !== 32'd0) begin errors++; $display("FAIL reset_out got=%0d want=0", out_o); end
      checks++; if (out_ch_o !== 3'd0) begin errors++; $display("FAIL reset_out_ch got=%0d want=0", out_ch_o); end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid_o); end
      checks++; if (cfg_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", cfg_ack_o); end
      do_reset();
   endtask

   task automatic test_basic();
      logic [N_CH-1:0] g; int lat; logic [31:0] y; logic [CH_W-1:0] och;
      do_reset();
      txn(0, X_POS, g, lat, y, och);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL basic_gnt got=%b want=0001", g); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d want=4", lat); end
      checks++; if (och !== 3'd0) begin errors++; $display("FAIL basic_ch got=%0d want=0", och); end
      checks++; if (y !== 32'd851443700) begin errors++; $display("FAIL basic_out got=%0d want=851443700", $signed(y)); end
      txn(0, X_POS, g, lat, y, och);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL repeat_gnt got=%b want=0001", g); end
      checks++; if (y !== 32'd8388600) begin errors++; $display("FAIL repeat_out got=%0d want=8388600", $signed(y)); end
   endtask

   task automatic test_neg_ch1();
      logic [N_CH-1:0] g; int lat; logic [31:0] y; logic [CH_W-1:0] och;
      do_reset();
      txn(1, X_NEG, g, lat, y, och);
      checks++; if (g !== 4'b0010) begin errors++; $display("FAIL ch1_gnt got=%b want=0010", g); end
      checks++; if (och !== 3'd1) begin errors++; $display("FAIL ch1_ch got=%0d want=1", och); end
      checks++; if ($signed(y) !== -32'sd851443700) begin errors++; $display("FAIL ch1_out got=%0d want=-851443700", $signed(y)); end
      txn(0, X_POS, g, lat, y, och);
      checks++; if (y !== 32'd851443700) begin errors++; $display("FAIL ch0_prev_isolated got=%0d want=851443700", $signed(y)); end
   endtask

   task automatic test_round_robin();
      int exp_ch [5] = '{0, 1, 2, 3, 0};
      int exp_cy [5] = '{0, 5, 10, 15, 20};
      int got_ch [5];
      int got_cy [5];
      int n = 0;
      int viol = 0;
      int bound;
      do_reset();
      req_i = '1;
      for (int cyc = 0; cyc < 25; cyc++) begin
         #1;
         if (gnt_o !== '0) begin
            if (busy_o) viol++;
            if (n < 5) begin
               got_cy[n] = cyc;
               got_ch[n] = -1;
               for (int b = 0; b < N_CH; b++) if (gnt_o == (4'b0001 << b)) got_ch[n] = b;
            end
            n++;
         end
         tick();
      end
      req_i = '0;
      checks++; if (n !== 5) begin errors++; $display("FAIL rr_grant_count got=%0d want=5", n); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL rr_gnt_while_busy got=%0d want=0", viol); end
      for (int i = 0; i < 5; i++) begin
         if (i < n) begin
            checks++; if (got_ch[i] !== exp_ch[i]) begin errors++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, got_ch[i], exp_ch[i]); end
            checks++; if (got_cy[i] !== exp_cy[i]) begin errors++; $display("FAIL rr_spacing[%0d] got=%0d want=%0d", i, got_cy[i], exp_cy[i]); end
         end
      end
      bound = 0;
      while (busy_o && bound < 20) begin tick(); bound++; end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b want=0", busy_o); end
   endtask

   task automatic test_cfg();
      logic [N_CH-1:0] g; int lat; logic [31:0] y; logic [CH_W-1:0] och;
      do_reset();
      cfg_we_i    = 1'b1;
      cfg_alpha_i = ONE;
      cfg_k_i     = ONE;
      req_i       = 4'b0001;
      sample_i[31:0] = X_POS;
      #1;
      checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL cfg_blocks_gnt got=%b want=0000", gnt_o); end
      tick();
      cfg_we_i = 1'b0;
      checks++; if (cfg_ack_o !== 1'b1) begin errors++; $display("FAIL cfg_ack got=%b want=1", cfg_ack_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cfg_stays_idle got=%b want=0", busy_o); end
      txn(0, X_POS, g, lat, y, och);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL cfg_then_gnt got=%b want=0001", g); end
      checks++; if (y !== 32'd1677721600) begin errors++; $display("FAIL cfg_new_coef_out got=%0d want=1677721600", $signed(y)); end
      checks++; if (cfg_ack_o !== 1'b0) begin errors++; $display("FAIL cfg_ack_pulse got=%b want=0", cfg_ack_o); end
      // Write attempt during MUL_K must be dropped.
      req_i = 4'b0001;
      sample_i[31:0] = X_POS;
      #1;
      checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL busy_cfg_gnt got=%b want=0001", gnt_o); end
      tick();
      req_i = '0;
      tick();
      cfg_we_i    = 1'b1;
      cfg_alpha_i = 32'd0;
      cfg_k_i     = 32'd0;
      tick();
      cfg_we_i = 1'b0;
      checks++; if (cfg_ack_o !== 1'b0) begin errors++; $display("FAIL busy_cfg_no_ack got=%b want=0", cfg_ack_o); end
      tick();
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL busy_cfg_valid got=%b want=1", out_valid_o); end
      checks++; if (out_o !== 32'd0) begin errors++; $display("FAIL busy_cfg_out got=%0d want=0", $signed(out_o)); end
      tick();
      txn(1, X_POS, g, lat, y, och);
      checks++; if (y !== 32'd1677721600) begin errors++; $display("FAIL coef_unchanged got=%0d want=1677721600", $signed(y)); end
   endtask

   task automatic test_reset_mid();
      logic [N_CH-1:0] g; int lat; logic [31:0] y; logic [CH_W-1:0] och;
      int seen = 0;
      do_reset();
      req_i = 4'b0001;
      sample_i[31:0] = X_POS;
      #1;
      checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL mid_gnt got=%b want=0001", gnt_o); end
      tick();
      req_i = '0;
      tick();
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid_o) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_valid got=%0d want=0", seen); end
      checks++; if (out_o !== 32'd0) begin errors++; $display("FAIL mid_out got=%0d want=0", $signed(out_o)); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy_o); end
      txn(0, X_POS, g, lat, y, och);
      checks++; if (y !== 32'd851443700) begin errors++; $display("FAIL mid_rerun got=%0d want=851443700", $signed(y)); end
   endtask

   initial begin
      Rst_n       = 1'b0;
      req_i       = '0;
      sample_i    = '0;
      cfg_we_i    = 1'b0;
      cfg_alpha_i = '0;
      cfg_k_i     = '0;
      test_reset();
      test_basic();
      test_neg_ch1();
      test_round_robin();
      test_cfg();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frac_channel_scheduler.md
Name: frac_channel_scheduler

Overview:
- Time-multiplexes one shared fractional-order (deformable-derivative) datapath across N_CH sample channels, arbitrated round-robin.
- Keeps per-channel previous-sample state and sequences the three multiplies through one 32x32 signed multiplier.
- Holds runtime-writable ALPHA / STEP_BETA coefficients and emits tagged results.
- Sits between the sampled-signal front ends and the downstream result consumer.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- CH_W, 3, width of channel index (>= clog2(N_CH)).
- ALPHA_RST, 8388608, reset ALPHA (0.5 in Q8.24).
- K_RST, 16861102, reset STEP_BETA coefficient (Q8.24).
- RATE, 100, final integer scale factor (1/STEP).

Ports:
- clk_100HZ  in  1  clock.
- Rst_n  in  1  reset, synchronous, active-low.
- req_i  in  N_CH  per-channel request; hold high with sample stable until granted.
- sample_i  in  32*N_CH  Q8.24 signed samples; channel c occupies bits [32c+31:32c].
- gnt_o  out  N_CH  one-hot, one-cycle pulse; sample of that channel captured this cycle.
- busy_o  out  1  high while not in IDLE.
- out_o  out  32  signed result, held until next result.
- out_ch_o  out  CH_W  channel index of out_o.
- out_valid_o  out  1  one-cycle pulse, out_o/out_ch_o valid.
- cfg_we_i  in  1  coefficient write strobe.
- cfg_alpha_i  in  32  new ALPHA (Q8.24).
- cfg_k_i  in  32  new STEP_BETA (Q8.24).
- cfg_ack_o  out  1  one-cycle pulse, write accepted.

Behaviour:
- Reset (Rst_n=0 at clock edge): state IDLE; gnt_o=0, busy_o=0, out_o=0, out_ch_o=0, out_valid_o=0, cfg_ack_o=0; all prev[c]=0; alpha=ALPHA_RST, k=K_RST; RR pointer=N_CH-1, so ch0 wins first.
- Reset mid-operation abandons the computation: no out_valid_o, prev not updated.
- FSM states: IDLE, MUL_A, MUL_K, MUL_R, DONE.
- IDLE, cfg_we_i=1: load alpha/k, pulse cfg_ack_o next cycle, issue no grant this cycle. Config has priority over requests.
- IDLE, no cfg_we_i, any req_i: grant the first requesting channel after the RR pointer (wrapping N_CH-1 -> 0).
  - Pulse gnt_o, latch x=sample and c=index, compute d = x - prev[c] (32-bit wrap), update pointer to c, go to MUL_A.
- IDLE, no requests: remain in IDLE.
- MUL_A: t2 = (d*alpha)[55:24] + x. Product is 64-bit signed; slicing [55:24] is an arithmetic floor; the add wraps at 32 bits.
- MUL_K: t3 = (t2*k)[55:24] - x.
- MUL_R: y = (t3*RATE)[31:0], registered into out_o; out_ch_o=c; prev[c]=x.
- DONE: out_valid_o=1 for this cycle only; go to IDLE.
- Latency and throughput:
  - Grant at cycle 0 gives out_valid_o at cycle 4.
  - Next grant no earlier than cycle 5, so at most one result per 5 cycles.
- cfg_we_i outside IDLE is ignored, with no ack; the caller must retry.
- Coefficients in use are those latched before the grant and stay stable through the operation.
- Only the multiplier is shared; all three multiplies use the same 32x32 signed instance.
- A req_i dropped before its grant is simply not serviced. A req_i still high after gnt_o is treated as a new request.

Decomposition:
- Shared package frac_pkg: Q8.24 constants (Q_FRAC=24, ONE=16777216), ALPHA_RST/K_RST defaults, FSM state enum.
- One sub-module: frac_rr_arbiter (N_CH-wide round-robin, pointer register, one-hot grant, encoded index).

Test Plan:
- Reset, ch0 only, x=16777216 -> gnt_o=0001 at cycle 0; at cycle 4 out_valid_o=1, out_ch_o=0, out_o=851443700.
- Repeat ch0 with x=16777216 -> out_o=8388600 (d=0, prev retained).
- ch1 x=-16777216 after reset -> out_o=-851443700, out_ch_o=1; ch0 prev unaffected.
- req_i=1111 held -> grant order ch0,ch1,ch2,ch3,ch0 with 5-cycle spacing; no gnt_o while busy_o=1.
- cfg_we_i with req_i both high in IDLE -> cfg_ack_o next cycle and no grant that cycle; cfg_we_i during MUL_K -> no ack, coefficients unchanged.
- Rst_n=0 during MUL_K -> no out_valid_o, out_o=0; rerun ch0 x=16777216 -> 851443700 (prev still 0).
